// File: rtl/cga_line_scaler.sv
// cga_line_scaler: captures one input scanline into a ping-pong buffer and
// replays the previous line SCALE times at SCALE x pixel rate, regenerating
// hsync/display-enable and optionally darkening the last repeat.
module cga_line_scaler #(
  parameter int unsigned PIX_W   = 4,
  parameter int unsigned MAX_PIX = 1024,
  parameter int unsigned SCALE   = 2,
  parameter int unsigned HS_W    = 64
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             in_ce,
  input  logic             line_reset,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             out_ce,
  input  logic             scanlines,
  output logic [PIX_W-1:0] video_o,
  output logic             hsync_o,
  output logic             de_o,
  output logic             ovf_o
);

  localparam int unsigned AW    = $clog2(MAX_PIX);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 2 * MAX_PIX;
  localparam logic [PW-1:0] FULL     = PW'(MAX_PIX);
  localparam logic [1:0]    REP_LAST = 2'(SCALE - 1);
  localparam bit            DARK_EN  = (SCALE > 1);

  typedef enum logic {IDLE = 1'b0, LINE = 1'b1} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   pos, pos_d;
  logic [1:0]      rep, rep_d;
  logic            fetch;

  logic            wr_bank;
  logic [PW-1:0]   wr_addr;
  logic [PW-1:0]   len;
  logic [PW-1:0]   last;
  logic            ovf_done;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_data;

  logic            stg_hs, stg_de, stg_dark;
  logic            in_hs;

  assign last  = len - PW'(1);
  assign in_hs = (32'(pos) < 32'(HS_W));

  // Output FSM state and replay counters.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state <= IDLE;
      pos   <= '0;
      rep   <= '0;
    end else begin
      state <= state_d;
      pos   <= pos_d;
      rep   <= rep_d;
    end
  end

  // Next-state: line_reset restarts from pos 0 on any clk; otherwise advance on out_ce.
  always_comb begin
    state_d = state;
    pos_d   = pos;
    rep_d   = rep;
    fetch   = 1'b0;
    if (line_reset) begin
      pos_d   = '0;
      rep_d   = '0;
      state_d = (wr_addr != '0) ? LINE : IDLE;
    end else if (out_ce && (state == LINE)) begin
      fetch = 1'b1;
      if (pos == last) begin
        pos_d = '0;
        if (rep == REP_LAST) begin
          rep_d   = '0;
          state_d = IDLE;
        end else begin
          rep_d = rep + 2'd1;
        end
      end else begin
        pos_d = pos + PW'(1);
      end
    end
  end

  // Write side: saturating address, bank swap and overflow pulse.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      len      <= '0;
      ovf_done <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      ovf_o <= 1'b0;
      if (line_reset) begin
        len      <= wr_addr;
        wr_bank  <= ~wr_bank;
        ovf_done <= 1'b0;
        wr_addr  <= in_ce ? PW'(1) : '0;
      end else if (in_ce) begin
        if (wr_addr != FULL) begin
          wr_addr <= wr_addr + PW'(1);
        end else if (!ovf_done) begin
          ovf_o    <= 1'b1;
          ovf_done <= 1'b1;
        end
      end
    end
  end

  // Ping-pong line buffer; the bank not being written is the replay bank.
  always_ff @(posedge clk) begin
    if (in_ce) begin
      if (line_reset) begin
        mem[{~wr_bank, {AW{1'b0}}}] <= pix_i;
      end else if (wr_addr != FULL) begin
        mem[{wr_bank, wr_addr[AW-1:0]}] <= pix_i;
      end
    end
    if (fetch) begin
      rd_data <= mem[{~wr_bank, pos[AW-1:0]}];
    end
  end

  // One-tick output pipeline aligned with the synchronous buffer read.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      stg_hs   <= 1'b0;
      stg_de   <= 1'b0;
      stg_dark <= 1'b0;
      hsync_o  <= 1'b0;
      de_o     <= 1'b0;
      video_o  <= '0;
    end else if (out_ce) begin
      stg_hs   <= fetch && in_hs;
      stg_de   <= fetch && !in_hs;
      stg_dark <= fetch && DARK_EN && scanlines && (rep == REP_LAST);
      hsync_o  <= stg_hs;
      de_o     <= stg_de;
      video_o  <= (stg_de && !stg_dark) ? rd_data : '0;
    end
  end

endmodule
